// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-mode codes and the
// baud divider helper. Used by the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Clocks per bit, integer-truncated.
  function automatic int calc_div(input int freq, input int speed);
    return freq / speed;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..DIVIDER-1 and pulses bit_end on the last clock
// of each bit. Held at 0 while restart is high so a new frame starts in phase.
module uart_baud_tick #(
  parameter int DIVIDER = 8
) (
  input  logic CLK_i,
  input  logic Reset_ni,
  input  logic restart,
  output logic bit_end
);

  localparam int              CW   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] tick_q;

  assign bit_end = (tick_q == LAST);

  // Tick counter: restart or end of bit returns it to 0, otherwise count up.
  always_ff @(posedge CLK_i or negedge Reset_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!Reset_ni)                tick_q <= '0;
    else if (restart || bit_end)  tick_q <= '0;
    else                          tick_q <= tick_q + 1'b1;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with valid/ready input, 1-entry holding
// buffer, runtime parity / stop-bit selection and registered Tx output.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int FREQUENCY = 50_000_000,
  parameter int SPEED     = 1_500_000,
  parameter int DATA_BITS = 8
) (
  input  logic                 CLK_i,
  input  logic                 Reset_ni,
  input  logic                 tx_valid_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_ready_o,
  input  logic [1:0]           parity_mode_i,
  input  logic                 stop2_i,
  output logic                 Tx,
  output logic                 busy_o
);

  localparam int         DIVIDER   = calc_div(FREQUENCY, SPEED);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);

  uart_state_t          state_q, state_d;
  logic                 load;
  logic                 tx_d;
  logic                 bit_end;
  logic                 accept;
  logic                 buf_full_q;
  logic [DATA_BITS-1:0] buf_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [3:0]           bit_cnt_q;
  logic                 par_q, par_en_q, stop2_q;
  logic                 tx_q, busy_q;

  assign accept     = tx_valid_i && !buf_full_q;
  assign tx_ready_o = !buf_full_q;
  assign Tx         = tx_q;
  assign busy_o     = busy_q;

  uart_baud_tick #(.DIVIDER(DIVIDER)) u_tick (
    .CLK_i    (CLK_i),
    .Reset_ni (Reset_ni),
    .restart  (state_q == IDLE),
    .bit_end  (bit_end)
  );

  // Next-state, load strobe and line level for the current bit.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    state_d = state_q;
    load    = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end && bit_cnt_q == LAST_DATA)
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_d = par_q;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end && bit_cnt_q == (stop2_q ? 4'd1 : 4'd0)) begin
          if (buf_full_q) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; Tx and busy are registered one cycle behind the state
  // so the pin is glitch-free and start follows an accept by two edges.
  always_ff @(posedge CLK_i or negedge Reset_ni) begin
    if (!Reset_ni) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= (state_q != IDLE);
    end
  end

  // Bit counter: indexes data bits and stop bits, cleared on every state change.
  always_ff @(posedge CLK_i or negedge Reset_ni) begin
    if (!Reset_ni)                bit_cnt_q <= '0;
    else if (state_d != state_q)  bit_cnt_q <= '0;
    else if (bit_end)             bit_cnt_q <= bit_cnt_q + 4'd1;
  end

  // Shift register and per-frame mode latched at load; shifts LSB first.
  always_ff @(posedge CLK_i or negedge Reset_ni) begin
    // NOTE: datapath registers are reset too; they are few and a defined
    // value after reset keeps the line and the parity bit deterministic.
    if (!Reset_ni) begin
      shift_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
    end else if (load) begin
      shift_q  <= buf_q;
      par_q    <= (parity_mode_i == PAR_ODD) ? ~^buf_q : ^buf_q;
      par_en_q <= (parity_mode_i == PAR_EVEN) || (parity_mode_i == PAR_ODD);
      stop2_q  <= stop2_i;
    end else if (state_q == DATA && bit_end) begin
      shift_q  <= shift_q >> 1;
    end
  end

  // Holding buffer: an accept wins over a simultaneous move to the shifter.
  always_ff @(posedge CLK_i or negedge Reset_ni) begin
    if (!Reset_ni) begin
      buf_full_q <= 1'b0;
      buf_q      <= '0;
    end else if (accept) begin
      buf_full_q <= 1'b1;
      buf_q      <= tx_data_i;
    end else if (load) begin
      buf_full_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame with DIVIDER=8 (FREQUENCY=8, SPEED=1).
// An 8-bit and a 7-bit instance share clock, reset and mode inputs.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       Reset_ni = 1'b0;
  logic       valid8 = 1'b0, valid7 = 1'b0;
  logic [7:0] data8 = '0;
  logic [6:0] data7 = '0;
  logic [1:0] mode = 2'b00;
  logic       stop2 = 1'b0;
  logic       ready8, ready7, tx8, tx7, busy8, busy7;
  logic       use7 = 1'b0;
  logic       tx_o, ready_o, busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame #(.FREQUENCY(8), .SPEED(1), .DATA_BITS(8)) dut8 (
    .CLK_i(CLK), .Reset_ni(Reset_ni), .tx_valid_i(valid8), .tx_data_i(data8),
    .tx_ready_o(ready8), .parity_mode_i(mode), .stop2_i(stop2), .Tx(tx8), .busy_o(busy8)
  );

  uart_tx_frame #(.FREQUENCY(8), .SPEED(1), .DATA_BITS(7)) dut7 (
    .CLK_i(CLK), .Reset_ni(Reset_ni), .tx_valid_i(valid7), .tx_data_i(data7),
    .tx_ready_o(ready7), .parity_mode_i(mode), .stop2_i(stop2), .Tx(tx7), .busy_o(busy7)
  );

  assign tx_o    = use7 ? tx7    : tx8;
  assign ready_o = use7 ? ready7 : ready8;
  assign busy_o  = use7 ? busy7  : busy8;

  typedef struct packed {
    logic [8:0]  data;
    logic [1:0]  mode;
    logic        stop2;
    logic        use7;
    logic [11:0] bits;   // frame bits in transmit order, bit 0 = start bit
    logic [3:0]  nbits;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one word when idle, then check timing of the whole frame clock by clock.
  task automatic send_frame(input vec_t v, input string tag);
    use7 = v.use7;
    @(negedge CLK);
    data8 = v.data[7:0]; data7 = v.data[6:0];
    mode = v.mode; stop2 = v.stop2;
    valid8 = !v.use7; valid7 = v.use7;
    @(negedge CLK);                       // accept edge passed
    valid8 = 1'b0; valid7 = 1'b0;
    check({tag, " ready_drop"}, ready_o, 0);
    check({tag, " tx_pre"}, tx_o, 1);
    @(negedge CLK);                       // load edge passed
    check({tag, " ready_after_load"}, ready_o, 1);
    check({tag, " busy_pre"}, busy_o, 0);
    check({tag, " tx_pre2"}, tx_o, 1);
    mode = ~v.mode; stop2 = ~v.stop2;     // must not affect this frame
    for (int k = 0; k < 8 * int'(v.nbits); k++) begin
      @(negedge CLK);
      check($sformatf("%s tx clk%0d", tag, k), tx_o, v.bits[k / 8]);
      check($sformatf("%s busy clk%0d", tag, k), busy_o, 1);
    end
    @(negedge CLK);
    check({tag, " tx_after"}, tx_o, 1);
    check({tag, " busy_after"}, busy_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] b2b;
    logic [29:0] three;
    logic [7:0]  words [3];
    int          t;

    // data, mode, stop2, use7, frame bits, bit count
    vecs[0] = '{9'h055, 2'b00, 1'b0, 1'b0, 12'h2AA, 4'd10};  // 8N1
    vecs[1] = '{9'h007, 2'b01, 1'b0, 1'b0, 12'h60E, 4'd11};  // even parity 1
    vecs[2] = '{9'h007, 2'b10, 1'b0, 1'b0, 12'h40E, 4'd11};  // odd parity 0
    vecs[3] = '{9'h0A1, 2'b10, 1'b1, 1'b0, 12'hD42, 4'd12};  // odd, 2 stop
    vecs[4] = '{9'h000, 2'b11, 1'b1, 1'b0, 12'h600, 4'd11};  // reserved = none
    vecs[5] = '{9'h0FF, 2'b01, 1'b0, 1'b0, 12'h5FE, 4'd11};  // even parity 0
    vecs[6] = '{9'h07F, 2'b00, 1'b1, 1'b1, 12'h3FE, 4'd10};  // 7 bits, 2 stop
    vecs[7] = '{9'h015, 2'b10, 1'b0, 1'b1, 12'h22A, 4'd10};  // 7 bits odd

    // Reset state.
    #12;
    check("reset tx", tx8, 1);
    check("reset ready", ready8, 1);
    check("reset busy", busy8, 0);
    check("reset ready7", ready7, 1);
    @(negedge CLK);
    Reset_ni = 1'b1;

    // Table-driven single frames.
    for (int i = 0; i < 8; i++) send_frame(vecs[i], $sformatf("vec%0d", i));

    // Back to back: 0xA1 then 0x3C, no idle gap between frames.
    use7 = 1'b0; mode = 2'b00; stop2 = 1'b0;
    b2b = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA1, 1'b0};
    @(negedge CLK);
    data8 = 8'hA1; valid8 = 1'b1;
    @(negedge CLK);
    data8 = 8'h3C;
    check("b2b ready_full", ready8, 0);
    @(negedge CLK);
    check("b2b ready_after_load", ready8, 1);
    for (int k = 0; k < 160; k++) begin
      @(negedge CLK);
      if (k == 0) valid8 = 1'b0;
      check($sformatf("b2b tx clk%0d", k), tx8, b2b[k / 8]);
      check($sformatf("b2b busy clk%0d", k), busy8, 1);
      if (k == 40) check("b2b ready_held", ready8, 0);
    end
    @(negedge CLK);
    check("b2b tx_after", tx8, 1);
    check("b2b busy_after", busy8, 0);

    // tx_valid_i held high across three words: exactly three frames.
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    three = {1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0};
    @(negedge CLK);
    fork
      begin
        valid8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
          data8 = words[i];
          t = 0;
          while (!ready8 && t < 400) begin
            @(negedge CLK);
            t++;
          end
          if (t >= 400) check($sformatf("hold ready_timeout w%0d", i), 1, 0);
          @(negedge CLK);
        end
        valid8 = 1'b0;
      end
      begin
        @(negedge CLK);
        @(negedge CLK);
        for (int k = 0; k < 240; k++) begin
          @(negedge CLK);
          check($sformatf("hold tx clk%0d", k), tx8, three[k / 8]);
          check($sformatf("hold busy clk%0d", k), busy8, 1);
        end
        for (int k = 0; k < 24; k++) begin
          @(negedge CLK);
          check($sformatf("hold idle tx%0d", k), tx8, 1);
          check($sformatf("hold idle busy%0d", k), busy8, 0);
        end
      end
    join

    // Asynchronous reset at clock 30 of a frame, then a clean frame.
    @(negedge CLK);
    data8 = 8'hAA; valid8 = 1'b1; mode = 2'b00; stop2 = 1'b0;
    @(negedge CLK);
    valid8 = 1'b0;
    @(negedge CLK);
    repeat (31) @(negedge CLK);
    check("rst pre_tx", tx8, 0);
    check("rst pre_busy", busy8, 1);
    #2 Reset_ni = 1'b0;
    #1;
    check("rst async_tx", tx8, 1);
    check("rst async_ready", ready8, 1);
    check("rst async_busy", busy8, 0);
    repeat (2) @(negedge CLK);
    Reset_ni = 1'b1;
    send_frame('{9'h00F, 2'b00, 1'b0, 1'b0, 12'h21E, 4'd10}, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
